// File: rtl/sw_led_hex_panel_if.sv
// sw_led_hex_panel_if -- board I/O bundle for the switch/LED/7-segment panel.
//
// The bundle carries no handshake. Each signal is a level:
//   sw   : board switches, already synchronised and sampled on every clk edge
//   ledr : LED chaser pattern, 1 = LED on
//   seg0 : 7-segment pattern, active-low (bit0=a .. bit6=g, bit7=dp)
// The master (board wrapper or bench) drives sw.
// The slave (the panel) drives ledr and seg0.
interface sw_led_hex_panel_if;
    logic [9:0]  sw;
    logic [15:0] ledr;
    logic [7:0]  seg0;

    modport master (
        output sw,
        input  ledr,
        input  seg0
    );

    modport slave (
        input  sw,
        output ledr,
        output seg0
    );
endinterface

// File: rtl/sw_led_hex_panel.sv
// sw_led_hex_panel -- switch/LED/7-segment demo panel.
//
//   * LED chaser: one lit LED rotates left every CNT_MAX cycles.
//   * 8-to-3 priority encoder on sw[7:0] (MSB wins), enabled by sw[8].
//   * BCD-to-7-segment decoder showing the encoder result on seg0,
//     enabled by sw[9].
//
// Optional build macro ENC_NOINPUT_DP_EN:
//   When defined, the decimal point (seg0[7]) lights when the encoder was
//   enabled with no data bit set. This separates "no input" from a real sw[0].
//   When undefined, the dp is always off.
//
// Reset is synchronous and active-high.
module sw_led_hex_panel #(
    parameter int unsigned CNT_MAX = 5000000   // cycles between rotations, >= 2
) (
    input  logic                 clk,
    input  logic                 rst,
    sw_led_hex_panel_if.slave    io
);

    // Terminal count of the rotation counter, sized to the 32-bit counter.
    localparam logic [31:0] CNT_LAST  = 32'(CNT_MAX - 1);
    localparam logic [15:0] LED_RESET = 16'h0001;
    localparam logic [7:0]  SEG_BLANK = 8'hFF;

    // ------------------------------------------------------------------
    // LED chaser
    // ------------------------------------------------------------------
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] led_q, led_d;
    logic        cnt_wrap;

    assign cnt_wrap = (cnt_q == CNT_LAST);

    // Next-state: count up, and on terminal count restart and rotate left.
    always_comb begin
        cnt_d = cnt_q + 32'd1;
        led_d = led_q;
        if (cnt_wrap) begin
            cnt_d = 32'd0;
            led_d = {led_q[14:0], led_q[15]};
        end
    end

    // Chaser state registers. Reset restarts the rotation period.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 32'd0;
            led_q <= LED_RESET;
        end else begin
            cnt_q <= cnt_d;
            led_q <= led_d;
        end
    end

    assign io.ledr = led_q;

    // ------------------------------------------------------------------
    // 8-to-3 priority encoder (MSB priority)
    // ------------------------------------------------------------------
    logic [2:0] y_q, y_d;

    // Ascending scan, so the highest set bit is the last one written.
    // A disabled encoder, or no data bit set, gives 0.
    always_comb begin
        y_d = 3'd0;
        if (io.sw[8]) begin
            for (int i = 0; i < 8; i++) begin
                if (io.sw[i]) begin
                    y_d = 3'(i);
                end
            end
        end
    end

    // Encoder output register: one cycle of latency from the switches.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= 3'd0;
        end else begin
            y_q <= y_d;
        end
    end

`ifdef ENC_NOINPUT_DP_EN
    // "Enabled but no input" flag. It is registered with y so that it
    // reaches seg0 in the same cycle as the digit it describes.
    logic noin_q, noin_d;

    // Flag when the encoder is enabled but no data bit is set.
    always_comb begin
        noin_d = io.sw[8] && (io.sw[7:0] == 8'h00);
    end

    // Flag register, aligned with y_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            noin_q <= 1'b0;
        end else begin
            noin_q <= noin_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // BCD-to-7-segment decoder (active-low, dp off in the table)
    // ------------------------------------------------------------------
    function automatic logic [7:0] seg_pattern(input logic [3:0] num);
        logic [7:0] pat;
        case (num)
            4'd0:    pat = 8'hC0;
            4'd1:    pat = 8'hF9;
            4'd2:    pat = 8'hA4;
            4'd3:    pat = 8'hB0;
            4'd4:    pat = 8'h99;
            4'd5:    pat = 8'h92;
            4'd6:    pat = 8'h82;
            4'd7:    pat = 8'hF8;
            4'd8:    pat = 8'h80;
            4'd9:    pat = 8'h90;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    logic [7:0] seg_q, seg_d;
    logic [3:0] num;

    assign num = {1'b0, y_q};

    // Display next-state: blank when disabled, otherwise decode the
    // registered encoder value.
    always_comb begin
        seg_d = SEG_BLANK;
        if (io.sw[9]) begin
            seg_d = seg_pattern(num);
`ifdef ENC_NOINPUT_DP_EN
            seg_d[7] = ~noin_q;
`endif
        end
    end

    // Display register: one cycle after y, or after a change of sw[9].
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= SEG_BLANK;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign io.seg0 = seg_q;

endmodule

// File: tb/tb_sw_led_hex_panel.sv
// tb_sw_led_hex_panel -- self-checking bench for sw_led_hex_panel.
// The reference model computes ledr from the cycle count since reset, the
// encoder value from log2 of the data, and the digit from a pattern table.
// Define ENC_NOINPUT_DP_EN for both the bench and the design to cover the
// dp build.
module tb_sw_led_hex_panel;

    localparam int CNT_MAX = 4;

    logic clk;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    sw_led_hex_panel_if bus ();

    sw_led_hex_panel #(.CNT_MAX(CNT_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    bit         m_valid = 0;
    int         m_cycles;          // edges since reset released
    int         m_y;               // registered encoder value
    bit         m_noin;            // registered "enabled, no data" flag
    logic [7:0] m_seg;
    logic [15:0] m_led;

    // Index of the highest set bit of d, or 0 when d is 0.
    function automatic int top_bit(input int d);
        if (d == 0) return 0;
        return $clog2(d + 1) - 1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid  = 1;
            m_cycles = 0;
            m_y      = 0;
            m_noin   = 0;
            m_seg    = 8'hFF;
        end else if (m_valid) begin
            if (bus.sw[9]) begin
                m_seg = seg_tab[m_y];
`ifdef ENC_NOINPUT_DP_EN
                if (m_noin) m_seg[7] = 1'b0;
`endif
            end else begin
                m_seg = 8'hFF;
            end
            m_y      = bus.sw[8] ? top_bit(int'(bus.sw[7:0])) : 0;
            m_noin   = bus.sw[8] && (bus.sw[7:0] == 8'h00);
            m_cycles = m_cycles + 1;
        end
        m_led = 16'd1 << ((m_cycles / CNT_MAX) % 16);
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare against the model on every cycle once the model is valid.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_ledr", bus.ledr, m_led);
            check("model_seg0", {8'h00, bus.seg0}, {8'h00, m_seg});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic [9:0] s);
        @(negedge clk);
        #1;
        rst    = r;
        bus.sw = s;
    endtask

    // Apply s, wait two edges, and check seg0 against a literal.
    task automatic seg_after2(input string name, input logic [9:0] s, input logic [7:0] exp);
        drive(1'b0, s);
        repeat (2) @(negedge clk);
        check(name, {8'h00, bus.seg0}, {8'h00, exp});
    endtask

    // Starts right after reset is released.
    task automatic chaser_from_release();
        repeat (3) @(negedge clk);
        check("led_hold_3", bus.ledr, 16'h0001);
        @(negedge clk);
        check("led_rot_4", bus.ledr, 16'h0002);
        repeat (4) @(negedge clk);
        check("led_rot_8", bus.ledr, 16'h0004);
    endtask

`ifdef ENC_NOINPUT_DP_EN
    localparam logic [7:0] NOIN_SEG = 8'h40;
`else
    localparam logic [7:0] NOIN_SEG = 8'hC0;
`endif

    // ---------------- stimulus ----------------
    initial begin
        rst    = 1'b1;
        bus.sw = 10'h000;
        repeat (2) @(negedge clk);
        check("reset_ledr", bus.ledr, 16'h0001);
        check("reset_seg0", {8'h00, bus.seg0}, 16'h00FF);

        // Chaser timing and full wrap.
        drive(1'b0, 10'h000);
        chaser_from_release();
        repeat (56) @(negedge clk);
        check("led_wrap_64", bus.ledr, 16'h0001);

        // Reset in the middle of a rotation period.
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("led_midreset", bus.ledr, 16'h0001);
        #1 rst = 1'b0;
        chaser_from_release();

        // Encoder and decoder with fixed data patterns.
        seg_after2("enc_25", 10'h325, 8'h92);
        seg_after2("enc_80", 10'h380, 8'hF8);
        seg_after2("enc_01", 10'h301, 8'hC0);

        // Priority sweep: the highest bit wins over bit 0.
        for (int i = 0; i < 8; i++) begin
            seg_after2($sformatf("sweep_%0d", i), 10'h300 | ((10'd1 << i) | (i > 0 ? 10'd1 : 10'd0)),
                       seg_tab[i]);
        end

        // Enable gating.
        seg_after2("enc_disabled", 10'h2FF, 8'hC0);
        drive(1'b0, 10'h1FF);
        @(negedge clk);
        check("disp_off_1cyc", {8'h00, bus.seg0}, 16'h00FF);

        // Reset values with every switch on, then recovery.
        drive(1'b1, 10'h3FF);
        @(negedge clk);
        check("rst_all_seg0", {8'h00, bus.seg0}, 16'h00FF);
        check("rst_all_ledr", bus.ledr, 16'h0001);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_release_seg0", {8'h00, bus.seg0}, 16'h00F8);

        // No-input flag on the decimal point.
        seg_after2("noinput_dp", 10'h300, NOIN_SEG);
        seg_after2("sw0_dp", 10'h301, 8'hC0);

        // Random stimulus with occasional resets; the model checks every cycle.
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 49) == 0, 10'($urandom_range(0, 1023)));
        end
        drive(1'b0, 10'h000);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sw_led_hex_panel.md
Name: sw_led_hex_panel

Overview:
- Board-level I/O panel block for the switch/LED/7-segment demo.
- Contains three sub-functions:
  - LED chaser ("light") driving 16 LEDs.
  - 8-to-3 priority encoder ("encoder83") on sw[7:0], enabled by sw[8].
  - BCD-to-7-segment decoder ("bcd7seg") showing the encoder result on seg0, enabled by sw[9].
- Sits beside the VGA/keyboard logic in the top level.

Parameters:
- CNT_MAX, 5000000, clock cycles between LED rotations (must be >= 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- sw  input  10  sw[7:0] encoder data, sw[8] encoder enable, sw[9] display enable
- ledr  output  16  LED chaser pattern, 1 = LED on
- seg0  output  8  7-segment pattern, active-low; bit0=a … bit6=g, bit7=dp

Behaviour:
- Single clock domain. Reset is synchronous and active-high: sampled on the clk rising edge, so it takes effect at the next edge.

LED chaser:
- State:
  - 32-bit counter cnt.
  - 16-bit register led, driven on ledr.
- Reset: cnt=0, led=16'h0001.
- Each cycle:
  - If cnt==CNT_MAX-1: cnt<=0 and led<={led[14:0],led[15]} (rotate left).
  - Otherwise cnt<=cnt+1.
- Timing:
  - First rotation is visible on the CNT_MAX-th rising edge after reset deasserts.
  - After 16 rotations the pattern returns to 16'h0001.
  - Exactly one bit is set at all times.

Encoder:
- Registered 3-bit output y.
- Reset: y=0.
- Each cycle:
  - If sw[8]==1: y <= index of the highest set bit of sw[7:0] (priority MSB).
  - sw[8]==1 with sw[7:0]==0: y<=0.
  - sw[8]==0: y<=0, regardless of data.
- Latency: 1 cycle.

Decoder:
- Registered output seg0. Input num = {1'b0,y}, 4 bits.
- Reset: seg0=8'hFF (all segments off).
- Each cycle:
  - If sw[9]==0: seg0<=8'hFF.
  - Otherwise seg0 <= pattern(num).
- Patterns (dp off, bit7=1):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99
  - 5=92, 6=82, 7=F8, 8=80, 9=90
  - 10–15 = FF (blank)
- Latency: 1 cycle from y, i.e. 2 cycles from sw[7:0]/sw[8] to seg0; 1 cycle from sw[9] to seg0.

Boundary conditions:
- Reset asserted mid-operation:
  - All state returns to reset values on that edge.
  - The counter restarts from 0, so the rotation period restarts.
- Simultaneous changes of sw[8] and sw[7:0] are simply sampled together on the same edge.
- No handshakes; switches are assumed already synchronised by the board wrapper.

Optional Feature:
- Macro: ENC_NOINPUT_DP_EN.
- Defined: seg0[7] (dp) is driven 0 (lit) when sw[9]==1, sw[8]==1 and sw[7:0]==0 was sampled two cycles earlier. This flags "enabled but no input" (distinguishes from a genuine sw[0]). A one-bit flag is registered alongside y to align it with seg0.
- Not defined: seg0[7] is always 1.
- All other bits and timing are identical in both builds.

Test Plan:
- Reset, then hold rst=0 with CNT_MAX=4:
  - ledr=0001 until the 4th edge, then 0002 → 0004 …
  - After 16 rotations (64 cycles) ledr=0001 again.
  - Assert rst mid-run → ledr=0001 next edge, and the next rotation comes 4 cycles after release.
- sw[9:8]=2'b11, sw[7:0]=8'b0010_0101:
  - y=5, seg0=8'h92 two cycles later.
  - Change to 8'h80 → seg0=8'hF8.
  - Change to 8'h01 → seg0=8'hC0.
- Priority sweep with sw[9:8]=11: for each i in 0..7, set sw[7:0] = (1<<i) | (i>0 ? 1 : 0) → seg0 = pattern(i).
- Enable gating:
  - sw[8]=0 with sw[7:0]=FF → seg0=C0 (digit 0).
  - sw[9]=0 → seg0=FF one cycle after the change, regardless of other inputs.
- Reset values: assert rst with sw=10'h3FF → after the edge seg0=FF, ledr=0001. After release, seg0=F8 two cycles later.
- ENC_NOINPUT_DP_EN build:
  - sw[9:8]=11, sw[7:0]=00 → seg0=8'h40.
  - Without the macro → seg0=8'hC0.
  - With sw[7:0]=01, both builds → seg0=8'hC0.
